// File: rtl/btn_conditioner.sv
// Push-button conditioner: per button a 2-FF synchronizer, a debounce counter and a press-pulse generator.
// Optional auto-repeat for the buttons selected by REPEAT_MASK is enabled by defining BTN_AUTOREPEAT_EN.
module btn_conditioner #(
  parameter int              NBTN          = 3,
  parameter int              DB_CYCLES     = 1000000,
  parameter int              CW            = 20,
  parameter int              REPEAT_DELAY  = 50000000,
  parameter int              REPEAT_PERIOD = 20000000,
  parameter logic [NBTN-1:0] REPEAT_MASK   = 'b100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_in,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_pulse
);

  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  // Reject configurations whose counters could wrap or whose repeat timing is meaningless.
  if (DB_CYCLES < 1 || longint'(DB_CYCLES) >= (longint'(1) << CW) ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY || $bits(REPEAT_MASK) != NBTN) begin : g_bad_cfg
    $error("btn_conditioner: inconsistent DB_CYCLES/CW/REPEAT_* parameters");
  end

  logic [NBTN-1:0] s1_q, s2_q;
  logic [NBTN-1:0] level_q, level_d;
  logic [NBTN-1:0] pulse_q, pulse_d;
  logic [NBTN-1:0] accept;

  genvar gi;
  for (gi = 0; gi < NBTN; gi++) begin : g_btn
    logic [CW-1:0] cnt_q, cnt_d;

    // A disagreement must persist DB_CYCLES consecutive cycles; any agreement restarts the count.
    assign accept[gi] = (s2_q[gi] != level_q[gi]) && (cnt_q == DB_LAST);
    assign cnt_d      = ((s2_q[gi] == level_q[gi]) || accept[gi]) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign level_d = level_q ^ accept;

`ifdef BTN_AUTOREPEAT_EN
  localparam int          RW         = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [NBTN-1:0] rpt_fire;

  for (gi = 0; gi < NBTN; gi++) begin : g_rpt
    if (REPEAT_MASK[gi]) begin : g_on
      logic [RW-1:0] rpt_q, rpt_d;

      // Timer counts cycles since the last pulse; reloading skips ahead so later pulses come every period.
      assign rpt_fire[gi] = level_q[gi] && level_d[gi] && (rpt_q == RPT_LAST);
      assign rpt_d        = !level_q[gi] ? '0 :
                            rpt_fire[gi] ? RPT_RELOAD : rpt_q + 1'b1;

      always_ff @(posedge clk) begin
        if (rst) begin
          rpt_q <= '0;
        end else begin
          rpt_q <= rpt_d;
        end
      end
    end else begin : g_off
      assign rpt_fire[gi] = 1'b0;
    end
  end

  assign pulse_d = (accept & ~level_q) | rpt_fire;
`else
  assign pulse_d = accept & ~level_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      pulse_q <= '0;
    end else begin
      s1_q    <= btn_in;
      s2_q    <= s1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: expected pulse/level events are queued at drive time and
// checked every cycle on the falling edge; cycles with no queued event must show no pulse.
module tb_btn_conditioner;

  localparam int DB  = 4;
  localparam int LAT = 2 + DB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn_in = 3'b111;
  logic [2:0] btn_level;
  logic [2:0] btn_pulse;

  btn_conditioner #(
    .NBTN(3), .DB_CYCLES(DB), .CW(3),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .REPEAT_MASK(3'b100)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(btn_level), .btn_pulse(btn_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] pulse;
    logic [2:0] level;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  logic [2:0] exp_level = 3'b000;
  logic [2:0] mon_pulse;
  string      mon_tag;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      mon_pulse = 3'b000;
      mon_tag   = "idle";
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        mon_e = sb.pop_front();
        tests++;
        assert (mon_e.cyc === cyc) else begin
          fails++;
          $error("FAIL %s event_cycle got=%0d exp=%0d", mon_e.tag, cyc, mon_e.cyc);
        end
        mon_pulse = mon_pulse | mon_e.pulse;
        exp_level = mon_e.level;
        mon_tag   = mon_e.tag;
      end
      tests++;
      assert (btn_pulse === mon_pulse) else begin
        fails++;
        $error("FAIL %s pulse cyc=%0d got=%b exp=%b", mon_tag, cyc, btn_pulse, mon_pulse);
      end
      tests++;
      assert (btn_level === exp_level) else begin
        fails++;
        $error("FAIL %s level cyc=%0d got=%b exp=%b", mon_tag, cyc, btn_level, exp_level);
      end
    end
  end

  task automatic drive(input logic [2:0] b);
    @(posedge clk);
    #1;
    btn_in = b;
  endtask

  task automatic expect_at(input int c, input logic [2:0] p, input logic [2:0] l, input string tag);
    exp_t e;
    e.cyc   = c;
    e.pulse = p;
    e.level = l;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  int p;

  initial begin
    // Buttons held through reset: a fresh press once reset lifts
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_at(cyc + LAT, 3'b111, 3'b111, "rst_held_press");
    idle(9);
    drive(3'b000);
    expect_at(cyc + LAT, 3'b000, 3'b000, "rst_held_release");
    idle(9);

    // Clean press and release
    drive(3'b001);
    expect_at(cyc + LAT, 3'b001, 3'b001, "clean_press");
    idle(9);
    drive(3'b000);
    expect_at(cyc + LAT, 3'b000, 3'b000, "clean_release");
    idle(9);

    // Bounce on btn1: every stable run is shorter than DB cycles until the final rise
    drive(3'b010); idle(1);
    drive(3'b000); idle(1);
    drive(3'b010); idle(1);
    drive(3'b000); idle(1);
    drive(3'b010);
    expect_at(cyc + LAT, 3'b010, 3'b010, "bounce_final");
    idle(9);
    drive(3'b000);
    expect_at(cyc + LAT, 3'b000, 3'b000, "bounce_release");
    idle(9);

    // Simultaneous press and release
    drive(3'b011);
    expect_at(cyc + LAT, 3'b011, 3'b011, "simul_press");
    idle(9);
    drive(3'b000);
    expect_at(cyc + LAT, 3'b000, 3'b000, "simul_release");
    idle(9);

    // Reset two cycles into a btn2 press discards the count
    drive(3'b100);
    idle(2);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    p = cyc + LAT;
    expect_at(p, 3'b100, 3'b100, "rst_mid_press");
`ifdef BTN_AUTOREPEAT_EN
    for (int k = p + 10; k < p + 40; k += 5) begin
      expect_at(k, 3'b100, 3'b100, "auto_repeat");
    end
`endif
    // Hold btn2 so its level drops exactly when a repeat would otherwise be due
    wait_until(p + 33);
    drive(3'b000);
    expect_at(cyc + LAT, 3'b000, 3'b000, "inc_held_release");
    idle(9);

    // btn0 is never auto-repeated: single pulse across a long hold
    drive(3'b001);
    p = cyc + LAT;
    expect_at(p, 3'b001, 3'b001, "start_held_press");
    wait_until(p + 30);
    drive(3'b000);
    expect_at(cyc + LAT, 3'b000, 3'b000, "start_held_release");
    idle(9);

    tests++;
    assert (sb.size() === 0) else begin
      fails++;
      $error("FAIL scoreboard_drain pending got=%0d exp=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
